// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared widths, M-stage FSM state type and address helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    function automatic logic is_misaligned(input logic [DATA_W-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wb_stage_if.sv
// ============================================================================
// Module      : mem_wb_stage_if
// Description : M-stage input bundle, stall and W-stage output bundle.
//               MisalignW exists only when MEM_ALIGN_CHECK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_wb_stage_if;
    import mips_pkg::*;

    logic [DATA_W-1:0]     ALUOutM;
    logic [DATA_W-1:0]     WriteDataM;
    logic [REG_ADDR_W-1:0] WriteRegM;
    logic                  RegWriteM;
    logic                  MemtoRegM;
    logic                  MemWriteM;

    logic                  StallM;
    logic [DATA_W-1:0]     ALUOutW;
    logic [DATA_W-1:0]     ReadDataW;
    logic [REG_ADDR_W-1:0] WriteRegW;
    logic                  RegWriteW;
    logic                  MemtoRegW;
`ifdef MEM_ALIGN_CHECK_EN
    logic                  MisalignW;
`endif

    modport master (
        output ALUOutM, WriteDataM, WriteRegM, RegWriteM, MemtoRegM, MemWriteM,
`ifdef MEM_ALIGN_CHECK_EN
        input  MisalignW,
`endif
        input  StallM, ALUOutW, ReadDataW, WriteRegW, RegWriteW, MemtoRegW
    );

    modport slave (
        input  ALUOutM, WriteDataM, WriteRegM, RegWriteM, MemtoRegM, MemWriteM,
`ifdef MEM_ALIGN_CHECK_EN
        output MisalignW,
`endif
        output StallM, ALUOutW, ReadDataW, WriteRegW, RegWriteW, MemtoRegW
    );

endinterface

`default_nettype wire

// File: rtl/mem_wb_stage_dmem_array.sv
// ============================================================================
// Module      : dmem_array
// Description : Single-port data memory, synchronous write, asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_array
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [DATA_W-1:0] i_wdata,
    output logic      [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module      : mem_wb_stage
// Description : MIPS memory-stage responder with multi-cycle access FSM and
//               MEM/WB register. Optional MEM_ALIGN_CHECK_EN adds MisalignW.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int MEM_LATENCY = 2
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mem_wb_stage_if.slave bus
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    mem_state_t            r_state;
    mem_state_t            w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;

    logic                  w_access;
    logic                  w_is_load;
    logic                  w_done;
    logic                  w_stall;
    logic                  w_misalign;
    logic                  w_we;
    logic [DATA_W-1:0]     w_rdata;

    logic [DATA_W-1:0]     r_alu_w;
    logic [DATA_W-1:0]     r_rdata_w;
    logic [REG_ADDR_W-1:0] r_wreg_w;
    logic                  r_regwrite_w;
    logic                  r_memtoreg_w;

    // A load+store combination behaves as a store only.
    assign w_access  = bus.MemtoRegM | bus.MemWriteM;
    assign w_is_load = bus.MemtoRegM & ~bus.MemWriteM;

    assign w_done  = w_access &
                     (((r_state == IDLE) & (MEM_LATENCY == 1)) |
                      ((r_state == BUSY) & (r_cnt == C_CNT_LAST)));
    assign w_stall = w_access & ~w_done;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = w_access & is_misaligned(bus.ALUOutM);
`else
    assign w_misalign = 1'b0;
`endif

    // Gating with rst keeps an aborted access from landing in memory.
    assign w_we = w_done & bus.MemWriteM & ~w_misalign & ~rst;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_dmem (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (bus.ALUOutM[ADDR_W+1:2]),
        .i_wdata (bus.WriteDataM),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_access && (MEM_LATENCY > 1)) begin
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = C_CNT_ONE;
                end
            end
            BUSY: begin
                if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + C_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Stalled cycles insert a bubble; the data fields simply hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_w      <= '0;
            r_rdata_w    <= '0;
            r_wreg_w     <= '0;
            r_regwrite_w <= 1'b0;
            r_memtoreg_w <= 1'b0;
        end else if (w_stall) begin
            r_regwrite_w <= 1'b0;
            r_memtoreg_w <= 1'b0;
        end else begin
            r_alu_w      <= bus.ALUOutM;
            r_rdata_w    <= w_is_load ? w_rdata : '0;
            r_wreg_w     <= bus.WriteRegM;
            r_regwrite_w <= bus.RegWriteM & ~(w_is_load & w_misalign);
            r_memtoreg_w <= w_is_load;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic r_misalign_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign_w <= 1'b0;
        end else begin
            r_misalign_w <= w_misalign & ~w_stall;
        end
    end

    assign bus.MisalignW = r_misalign_w;
`endif

    assign bus.StallM    = w_stall;
    assign bus.ALUOutW   = r_alu_w;
    assign bus.ReadDataW = r_rdata_w;
    assign bus.WriteRegW = r_wreg_w;
    assign bus.RegWriteW = r_regwrite_w;
    assign bus.MemtoRegW = r_memtoreg_w;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Directed bench for mem_wb_stage at MEM_LATENCY 1..4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic [4:1]  rst_v;
    logic [31:0] alu, wd;
    logic [4:0]  wreg;
    logic        regw, m2r, mw;
    int          total = 0;
    int          bad   = 0;

    logic        stall_v [1:4];
    logic [31:0] alu_v   [1:4];
    logic [31:0] rd_v    [1:4];
    logic [4:0]  wreg_v  [1:4];
    logic        regw_v  [1:4];
    logic        m2r_v   [1:4];

    always #5 clk = ~clk;

    mem_wb_stage_if b1 ();
    mem_wb_stage_if b2 ();
    mem_wb_stage_if b3 ();
    mem_wb_stage_if b4 ();

    mem_wb_stage #(.DEPTH_WORDS(256), .MEM_LATENCY(1)) u1 (.clk(clk), .rst(rst_v[1]), .bus(b1.slave));
    mem_wb_stage #(.DEPTH_WORDS(256), .MEM_LATENCY(2)) u2 (.clk(clk), .rst(rst_v[2]), .bus(b2.slave));
    mem_wb_stage #(.DEPTH_WORDS(256), .MEM_LATENCY(3)) u3 (.clk(clk), .rst(rst_v[3]), .bus(b3.slave));
    mem_wb_stage #(.DEPTH_WORDS(256), .MEM_LATENCY(4)) u4 (.clk(clk), .rst(rst_v[4]), .bus(b4.slave));

    `define TB_HOOK(B, K) \
        assign B.ALUOutM = alu; assign B.WriteDataM = wd; assign B.WriteRegM = wreg; \
        assign B.RegWriteM = regw; assign B.MemtoRegM = m2r; assign B.MemWriteM = mw; \
        assign stall_v[K] = B.StallM; assign alu_v[K] = B.ALUOutW; assign rd_v[K] = B.ReadDataW; \
        assign wreg_v[K] = B.WriteRegW; assign regw_v[K] = B.RegWriteW; assign m2r_v[K] = B.MemtoRegW;

    `TB_HOOK(b1, 1)
    `TB_HOOK(b2, 2)
    `TB_HOOK(b3, 3)
    `TB_HOOK(b4, 4)
    `undef TB_HOOK

`ifdef MEM_ALIGN_CHECK_EN
    logic mis3;
    assign mis3 = b3.MisalignW;
`endif

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                         input logic rw, input logic ld, input logic st);
        alu = a; wd = d; wreg = r; regw = rw; m2r = ld; mw = st;
    endtask

    task automatic idle;
        drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Presents one access to instance k, checks stall/bubble per cycle,
    // and returns just after the done edge with idle inputs.
    task automatic access(input int k, input int lat, input string tag,
                          input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                          input logic rw, input logic ld, input logic st);
        drive(a, d, r, rw, ld, st);
        for (int i = 0; i < lat; i++) begin
            #1;
            chk({tag, "_stall"}, {31'b0, stall_v[k]}, (i < lat - 1) ? 32'd1 : 32'd0);
            tick;
            if (i < lat - 1) chk({tag, "_bubble"}, {31'b0, regw_v[k]}, 32'd0);
        end
        idle;
    endtask

    initial begin
        rst_v = '1;
        idle;
        @(posedge clk);
        #1;
        chk("rst_alu",   alu_v[2], 32'h0);
        chk("rst_rd",    rd_v[2], 32'h0);
        chk("rst_wreg",  {27'b0, wreg_v[2]}, 32'h0);
        chk("rst_regw",  {31'b0, regw_v[2]}, 32'h0);
        chk("rst_m2r",   {31'b0, m2r_v[2]}, 32'h0);
        chk("rst_stall", {31'b0, stall_v[2]}, 32'h0);

        // Non-access pass-through, latency 2
        rst_v[2] = 1'b0;
        drive(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
        #1;
        chk("pt_stall0", {31'b0, stall_v[2]}, 32'h0);
        tick;
        chk("pt_alu",    alu_v[2], 32'h1234);
        chk("pt_wreg",   {27'b0, wreg_v[2]}, 32'd5);
        chk("pt_regw",   {31'b0, regw_v[2]}, 32'd1);
        chk("pt_m2r",    {31'b0, m2r_v[2]}, 32'd0);
        chk("pt_rd",     rd_v[2], 32'h0);
        chk("pt_stall1", {31'b0, stall_v[2]}, 32'h0);
        idle;

        // Store then load, latency 3, back-to-back
        rst_v[3] = 1'b0;
        access(3, 3, "st10", 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("st10_alu",  alu_v[3], 32'h10);
        chk("st10_m2r",  {31'b0, m2r_v[3]}, 32'd0);
        access(3, 3, "ld10", 32'h10, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0);
        chk("ld10_rd",   rd_v[3], 32'hDEADBEEF);
        chk("ld10_m2r",  {31'b0, m2r_v[3]}, 32'd1);
        chk("ld10_regw", {31'b0, regw_v[3]}, 32'd1);
        chk("ld10_wreg", {27'b0, wreg_v[3]}, 32'd7);

        // Address wrap modulo 1 KiB
        access(3, 3, "st400", 32'h400, 32'hA5A5A5A5, 5'd0, 1'b0, 1'b0, 1'b1);
        access(3, 3, "ld000", 32'h000, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0);
        chk("wrap_rd",   rd_v[3], 32'hA5A5A5A5);

        // Reset in the 2nd BUSY cycle of a store, latency 4
        rst_v[4] = 1'b0;
        access(4, 4, "st40a", 32'h40, 32'h11110000, 5'd0, 1'b0, 1'b0, 1'b1);
        drive(32'h40, 32'h22222222, 5'd0, 1'b0, 1'b0, 1'b1);
        tick;
        tick;
        rst_v[4] = 1'b1;
        #1;
        chk("rstm_alu",  alu_v[4], 32'h0);
        chk("rstm_regw", {31'b0, regw_v[4]}, 32'd0);
        idle;
        tick;
        tick;
        rst_v[4] = 1'b0;
        access(4, 4, "ld40", 32'h40, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0);
        chk("rstm_rd",   rd_v[4], 32'h11110000);
        chk("rstm_wreg", {27'b0, wreg_v[4]}, 32'd9);

        // Latency 1: alternating store/load, no stall
        rst_v[1] = 1'b0;
        access(1, 1, "l1st7", 32'h20, 32'h7, 5'd0, 1'b0, 1'b0, 1'b1);
        access(1, 1, "l1ld7", 32'h20, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0);
        chk("l1_rd7",    rd_v[1], 32'h7);
        chk("l1_m2r",    {31'b0, m2r_v[1]}, 32'd1);
        access(1, 1, "l1st8", 32'h20, 32'h8, 5'd0, 1'b0, 1'b0, 1'b1);
        access(1, 1, "l1ld8", 32'h20, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0);
        chk("l1_rd8",    rd_v[1], 32'h8);

`ifdef MEM_ALIGN_CHECK_EN
        access(3, 3, "al_st20", 32'h20, 32'h5555AAAA, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("al_mis0",   {31'b0, mis3}, 32'd0);
        access(3, 3, "al_st22", 32'h22, 32'h11111111, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("al_mis_st", {31'b0, mis3}, 32'd1);
        access(3, 3, "al_ld20", 32'h20, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0);
        chk("al_keep",   rd_v[3], 32'h5555AAAA);
        chk("al_mis1",   {31'b0, mis3}, 32'd0);
        access(3, 3, "al_ld21", 32'h21, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0);
        chk("al_mis_ld", {31'b0, mis3}, 32'd1);
        chk("al_regw",   {31'b0, regw_v[3]}, 32'd0);
`endif

        tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-stage responder and MEM/WB pipeline register for the MIPS pipeline. It consumes the memory-stage bundle produced by the EX/MEM register, performs the data-memory access over a configurable number of cycles, and raises a stall to the hazard unit while the access is in flight. It registers the result into the writeback-stage bundle.

## Interface
Parameters:
- DEPTH_WORDS, 256: data-memory depth in 32-bit words; power of two.
- MEM_LATENCY, 2: cycles a load or store occupies the M stage; must be at least 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- ALUOutM  input  32  byte address for an access, or the ALU result for non-memory instructions.
- WriteDataM  input  32  store data.
- WriteRegM  input  5  destination register.
- RegWriteM  input  1  register-write enable.
- MemtoRegM  input  1  load; selects memory data at writeback.
- MemWriteM  input  1  store.
- StallM  output  1  combinational; holds F/D/E/M stages upstream.
- ALUOutW  output  32  registered ALUOutM.
- ReadDataW  output  32  registered load data.
- WriteRegW  output  5  registered WriteRegM.
- RegWriteW  output  1  registered RegWriteM, or 0 for a bubble.
- MemtoRegW  output  1  registered MemtoRegM, or 0 for a bubble.

## Operation
- access = MemtoRegM | MemWriteM. If both are set, the access is treated as a store only, and MemtoRegW is forced to 0.
- Word index is ALUOutM[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4. Without the alignment feature, bits [1:0] are ignored.
- FSM states:
  - IDLE. If access and MEM_LATENCY>1, go to BUSY with cnt=1.
  - BUSY. cnt increments each cycle. When cnt==MEM_LATENCY-1, return to IDLE.
- done = access & ((state==IDLE & MEM_LATENCY==1) | (state==BUSY & cnt==MEM_LATENCY-1)).
- StallM = access & ~done.
- Upstream holds all M inputs stable while StallM=1. Inputs that change during BUSY are undefined usage.
- Store: a single memory write on the done edge only. Stalled cycles never write.
- Load: ReadDataW captures mem[index] on the done edge.
- Non-access instructions pass through in one cycle, with no stall and no memory effect. ReadDataW is loaded with 0.
- Bubble: while StallM=1, the W register loads RegWriteW=0 and MemtoRegW=0. The other W fields are don't-care but are driven deterministically (held).

## Timing
- Reset values: state=IDLE, cnt=0, all W outputs 0. StallM follows its inputs combinationally; it is 0 after reset when no access is present. Memory array contents are not reset.
- Latency from M to W: 1 cycle for non-access instructions; MEM_LATENCY cycles for loads and stores. StallM is high for the first MEM_LATENCY-1 of those cycles.
- A store completing on edge N is visible to a load whose done edge is N+1 or later.
- Back-to-back accesses: BUSY returns to IDLE on the done edge. A following access starts its count on the next cycle with no idle gap.
- Reset asserted mid-access: the FSM aborts to IDLE, no write occurs, and W outputs clear immediately.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - Adds output MisalignW (1 bit, registered, reset 0). It is set for one W cycle when a completing access has ALUOutM[1:0]!=0.
  - A misaligned store is suppressed.
  - A misaligned load completes with RegWriteW forced to 0.
  - Latency is unchanged.
- Not defined: the port is absent, bits [1:0] are ignored, and no suppression occurs.

## Structure
- Shared package mips_pkg holds:
  - the constants DATA_W=32 and REG_ADDR_W=5;
  - the mem_state_t enum {IDLE, BUSY}.
- Sub-module dmem_array: single-port, DEPTH_WORDS×32, synchronous write with write enable, asynchronous read. The FSM, counter and W register remain in mem_wb_stage.

## Test plan
- Non-access pass-through (MEM_LATENCY=2): ALUOutM=0x1234, RegWriteM=1, WriteRegM=5 → next cycle ALUOutW=0x1234, WriteRegW=5, RegWriteW=1; StallM never asserts.
- Store then load (MEM_LATENCY=3):
  - Store 0xDEADBEEF at address 0x10 → StallM high for 2 cycles; a single write occurs on the 3rd edge.
  - A following load of 0x10 → after 3 cycles, ReadDataW=0xDEADBEEF, MemtoRegW=1; RegWriteW=0 during the 2 bubble cycles.
- Wrap-around (DEPTH_WORDS=256): store 0xA5A5A5A5 at 0x400, then load 0x000 → ReadDataW=0xA5A5A5A5.
- Reset mid-store (MEM_LATENCY=4): assert rst in the 2nd BUSY cycle → state IDLE, W outputs 0. A subsequent load of that address returns the pre-store value.
- MEM_LATENCY=1: alternating store/load to 0x20 with 0x00000007 → StallM is always 0, and the load returns 7 one cycle after its M cycle.
- With MEM_ALIGN_CHECK_EN:
  - Store 0x11111111 at 0x22 → MisalignW=1 and memory at word 8 is unchanged.
  - Load 0x21 → MisalignW=1 and RegWriteW=0.
